if_inst_buffer: RTL and testbench

- Consumer end of the fetch interface: a 2-wide instruction queue between the fetch stage and decode.
- Accepts up to two instructions per cycle from fetch and presents the two oldest instructions to decode.
- Drives the fetch back-pressure pair: no instructions (`non_ins_en_out`) or one instruction only (`one_ins_en_out`).
- Absorbs decode stalls so fetch keeps streaming 64-bit Imem words.

---
 rtl/if_inst_buffer.sv | 119 +++++++++++
 tb/tb_if_inst_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_inst_buffer.sv
// rtl/if_inst_buffer.sv - 2-wide instruction queue between fetch and decode
module if_inst_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      if_IRA_in,
    input  logic [31:0]      if_IRB_in,
    input  logic             if_valid_instA_in,
    input  logic             if_valid_instB_in,
    input  logic [1:0]       id_take_cnt_in,
    input  logic             flush_in,
    output logic [31:0]      ib_IRA_out,
    output logic [31:0]      ib_IRB_out,
    output logic             ib_valid_instA_out,
    output logic             ib_valid_instB_out,
    output logic             non_ins_en_out,
    output logic             one_ins_en_out,
    output logic [PTR_W:0]   ib_count_out
);

    localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_TWO   = (PTR_W+1)'(2);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [PTR_W:0]   free_w;
    logic             full_w;
    logic             one_slot_w;
    logic             wr0_en;
    logic             wr1_en;
    logic [31:0]      wr0_data;
    logic [1:0]       n_wr;
    logic [1:0]       take_req;
    logic [1:0]       take;
    logic [PTR_W-1:0] tail_p1;
    logic [PTR_W-1:0] head_p1;

    // Back-pressure decoded from registered occupancy only, so it is stable for the whole cycle
    always_comb begin
        free_w     = CNT_DEPTH - count_q;
        full_w     = (free_w == '0);
        one_slot_w = (free_w == (PTR_W+1)'(1));
    end

    // Write selection, dequeue clamp and next-state pointers; flush overrides everything
    always_comb begin
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = if_valid_instA_in ? if_IRA_in : if_IRB_in;
        n_wr     = 2'd0;
        take_req = (id_take_cnt_in == 2'd3) ? 2'd2 : id_take_cnt_in;
        take     = (count_q < (PTR_W+1)'(take_req)) ? count_q[1:0] : take_req;
        tail_p1  = tail_q + PTR_W'(1);
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Slot 0 takes the oldest valid input; slot 1 only when both are valid and room for two
            wr0_en = (if_valid_instA_in || if_valid_instB_in) && !full_w;
            wr1_en = if_valid_instA_in && if_valid_instB_in && !full_w && !one_slot_w;
            n_wr   = {1'b0, wr0_en} + {1'b0, wr1_en};
            head_d  = head_q + PTR_W'(take);
            tail_d  = tail_q + PTR_W'(n_wr);
            count_d = count_q + (PTR_W+1)'(n_wr) - (PTR_W+1)'(take);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; two write ports at consecutive tail slots
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr0_en) begin
                mem_q[tail_q] <= wr0_data;
            end
            if (wr1_en) begin
                mem_q[tail_p1] <= if_IRB_in;
            end
        end
    end

    // Decode-side view: two oldest entries, zeroed when not valid
    always_comb begin
        head_p1            = head_q + PTR_W'(1);
        ib_valid_instA_out = (count_q != '0);
        ib_valid_instB_out = (count_q >= CNT_TWO);
        ib_IRA_out         = ib_valid_instA_out ? mem_q[head_q]  : 32'h0;
        ib_IRB_out         = ib_valid_instB_out ? mem_q[head_p1] : 32'h0;
        non_ins_en_out     = full_w;
        one_ins_en_out     = one_slot_w;
        ib_count_out       = count_q;
    end

endmodule

// File: tb/tb_if_inst_buffer.sv
// tb/tb_if_inst_buffer.sv - scoreboard bench for if_inst_buffer
module tb_if_inst_buffer;

    logic        clock;
    logic        reset;
    logic [31:0] if_IRA_in;
    logic [31:0] if_IRB_in;
    logic        if_valid_instA_in;
    logic        if_valid_instB_in;
    logic [1:0]  id_take_cnt_in;
    logic        flush_in;
    logic [31:0] ib_IRA_out;
    logic [31:0] ib_IRB_out;
    logic        ib_valid_instA_out;
    logic        ib_valid_instB_out;
    logic        non_ins_en_out;
    logic        one_ins_en_out;
    logic [3:0]  ib_count_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    if_inst_buffer #(.DEPTH(8), .PTR_W(3)) dut (
        .clock              (clock),
        .reset              (reset),
        .if_IRA_in          (if_IRA_in),
        .if_IRB_in          (if_IRB_in),
        .if_valid_instA_in  (if_valid_instA_in),
        .if_valid_instB_in  (if_valid_instB_in),
        .id_take_cnt_in     (id_take_cnt_in),
        .flush_in           (flush_in),
        .ib_IRA_out         (ib_IRA_out),
        .ib_IRB_out         (ib_IRB_out),
        .ib_valid_instA_out (ib_valid_instA_out),
        .ib_valid_instB_out (ib_valid_instB_out),
        .non_ins_en_out     (non_ins_en_out),
        .one_ins_en_out     (one_ins_en_out),
        .ib_count_out       (ib_count_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the scoreboard contents
    task automatic check_outputs();
        int sz;
        int free;
        sz   = exp_q.size();
        free = 8 - sz;
        check_eq("count",  32'(ib_count_out), 32'(sz));
        check_eq("validA", 32'(ib_valid_instA_out), 32'(sz >= 1));
        check_eq("validB", 32'(ib_valid_instB_out), 32'(sz >= 2));
        check_eq("IRA",    ib_IRA_out, (sz >= 1) ? exp_q[0] : 32'h0);
        check_eq("IRB",    ib_IRB_out, (sz >= 2) ? exp_q[1] : 32'h0);
        check_eq("non_en", 32'(non_ins_en_out), 32'(free == 0));
        check_eq("one_en", 32'(one_ins_en_out), 32'(free == 1));
    endtask

    // One clock: check current outputs, drive inputs, update scoreboard, advance to edge+1
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic va, input logic vb,
                        input logic [1:0] take, input logic fl);
        int free;
        int t;
        check_outputs();
        if_IRA_in         = a;
        if_IRB_in         = b;
        if_valid_instA_in = va;
        if_valid_instB_in = vb;
        id_take_cnt_in    = take;
        flush_in          = fl;
        free = 8 - exp_q.size();
        if (fl) begin
            exp_q.delete();
        end else begin
            t = (take == 2'd3) ? 2 : int'(take);
            if (t > exp_q.size()) t = exp_q.size();
            for (int i = 0; i < t; i++) begin
                if (i == 0) check_eq("pop0", ib_IRA_out, exp_q[0]);
                else        check_eq("pop1", ib_IRA_out == exp_q[0] ? ib_IRB_out : ib_IRB_out, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (free >= 2) begin
                if (va) exp_q.push_back(a);
                if (vb) exp_q.push_back(b);
            end else if (free == 1) begin
                if (va)      exp_q.push_back(a);
                else if (vb) exp_q.push_back(b);
            end
        end
        @(posedge clock);
        #1;
        if_valid_instA_in = 1'b0;
        if_valid_instB_in = 1'b0;
        id_take_cnt_in    = 2'd0;
        flush_in          = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_IRA"},   ib_IRA_out, 32'h0);
        check_eq({tag, "_IRB"},   ib_IRB_out, 32'h0);
        check_eq({tag, "_vA"},    32'(ib_valid_instA_out), 32'h0);
        check_eq({tag, "_vB"},    32'(ib_valid_instB_out), 32'h0);
        check_eq({tag, "_non"},   32'(non_ins_en_out), 32'h0);
        check_eq({tag, "_one"},   32'(one_ins_en_out), 32'h0);
        check_eq({tag, "_count"}, 32'(ib_count_out), 32'h0);
    endtask

    initial begin
        reset             = 1'b0;
        if_IRA_in         = '0;
        if_IRB_in         = '0;
        if_valid_instA_in = 1'b0;
        if_valid_instB_in = 1'b0;
        id_take_cnt_in    = 2'd0;
        flush_in          = 1'b0;

        // 1. reset, then write a pair
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("rst");
        reset = 1'b1;
        step(32'h1111_1111, 32'h2222_2222, 1, 1, 0, 0);
        check_eq("t1_IRA", ib_IRA_out, 32'h1111_1111);
        check_eq("t1_IRB", ib_IRB_out, 32'h2222_2222);
        check_eq("t1_count", 32'(ib_count_out), 32'd2);

        // 2. fill to full
        step(32'h3333_3333, 32'h4444_4444, 1, 1, 0, 0);
        step(32'h5555_5555, 32'h6666_6666, 1, 1, 0, 0);
        check_eq("t2_count6", 32'(ib_count_out), 32'd6);
        check_eq("t2_non6", 32'(non_ins_en_out), 32'd0);
        check_eq("t2_one6", 32'(one_ins_en_out), 32'd0);
        step(32'h7777_7777, 32'h8888_8888, 1, 1, 0, 0);
        check_eq("t2_count8", 32'(ib_count_out), 32'd8);
        check_eq("t2_non8", 32'(non_ins_en_out), 32'd1);
        check_eq("t2_one8", 32'(one_ins_en_out), 32'd0);
        step(32'h9999_9999, 32'hCCCC_CCCC, 1, 1, 0, 0);
        check_eq("t2_ignored", 32'(ib_count_out), 32'd8);

        // 3. one-slot limit: take 1 with a pair offered while full, then pair at count 7
        step(32'hDEAD_0000, 32'hDEAD_0001, 1, 1, 1, 0);
        check_eq("t3_count7", 32'(ib_count_out), 32'd7);
        check_eq("t3_one", 32'(one_ins_en_out), 32'd1);
        step(32'hAAAA_0000, 32'hBBBB_0000, 1, 1, 0, 0);
        check_eq("t3_count8", 32'(ib_count_out), 32'd8);
        // at full with take=2: no write, two free next cycle
        step(32'hDEAD_0002, 32'hDEAD_0003, 1, 1, 2, 0);
        check_eq("t3_full_take", 32'(ib_count_out), 32'd6);
        // drain with take=3 (clamped to 2), excess take at the end clamped silently
        for (int i = 0; i < 4; i++) step(32'h0, 32'h0, 0, 0, 3, 0);
        check_eq("t3_empty", 32'(ib_count_out), 32'd0);

        // 4. wrap-around streaming 0..19, two per cycle in and out
        step(32'd0, 32'd1, 1, 1, 2, 0);
        for (int k = 1; k < 10; k++) begin
            check_eq("t4_count", 32'(ib_count_out), 32'd2);
            step(32'(2*k), 32'(2*k+1), 1, 1, 2, 0);
        end
        step(32'h0, 32'h0, 0, 0, 2, 0);
        check_eq("t4_drained", 32'(ib_count_out), 32'd0);

        // B-only write goes into tail alone; single take
        step(32'hFFFF_FFFF, 32'h0000_BEEF, 0, 1, 0, 0);
        step(32'h0000_CAFE, 32'h0, 1, 0, 1, 0);
        step(32'h0, 32'h0, 0, 0, 1, 0);

        // 5. flush priority at count 5
        step(32'h5000_0001, 32'h5000_0002, 1, 1, 0, 0);
        step(32'h5000_0003, 32'h5000_0004, 1, 1, 0, 0);
        step(32'h0, 32'h5000_0005, 0, 1, 0, 0);
        check_eq("t5_count5", 32'(ib_count_out), 32'd5);
        step(32'h5000_0006, 32'h5000_0007, 1, 1, 2, 1);
        check_all_zero("flush");
        step(32'h5100_0001, 32'h5100_0002, 1, 1, 0, 0);
        check_eq("t5_after_IRA", ib_IRA_out, 32'h5100_0001);

        // 6. asynchronous reset mid-stream at count 4
        step(32'h6000_0001, 32'h6000_0002, 1, 1, 0, 0);
        check_eq("t6_count4", 32'(ib_count_out), 32'd4);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("areset");
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(32'h7000_0001, 32'h7000_0002, 1, 1, 0, 0);
        check_eq("t6_IRA", ib_IRA_out, 32'h7000_0001);
        check_eq("t6_IRB", ib_IRB_out, 32'h7000_0002);
        step(32'h0, 32'h0, 0, 0, 2, 0);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
